lbm_step_sequencer: RTL

//  Time-step controller for the LBM solver datapath and its 9 ping-pong RAM pairs (f / f_n).

---
 rtl/lbm_step_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/lbm_step_sequencer.sv
// -----------------------------------------------------------------------------
// lbm_step_sequencer
//
// Time-step controller for the LBM solver datapath and its ping-pong RAM
// pairs (f / f_n). Each step runs collide -> drain -> stream -> swap, and a
// host may park the sequencer in HOLD at a step boundary for coherent reads.
//
// Ports
//   clk_i             rising-edge clock
//   rst_ni            asynchronous reset, active-low
//   en_i              global advance; low freezes every register
//   start_i           1-cycle pulse, begins a run of step_target_i steps
//   step_target_i     steps per run, sampled on an accepted start
//   host_hold_req_i   host asks for a stall at the next step boundary
//   host_hold_ack_o   high while parked in HOLD
//   rd_en_o/rd_addr_o         collider read strobe / node address
//   wr_en_o/wr_addr_o         collider write-back strobe / node address
//   stream_en_o/stream_addr_o streaming strobe / node address
//   phase_o           0 IDLE, 1 COLLIDE, 2 DRAIN, 3 STREAM, 4 SWAP, 5 HOLD
//   buf_sel_o         0: f is source, 1: f_n is source
//   steps_done_o      completed steps in the current run
//   busy_o            phase != IDLE
//   done_o            1-cycle pulse when a run completes
//
// States
//   IDLE    | waiting for start
//   COLLIDE | issuing collider reads, node 0..NODES-1
//   DRAIN   | PIPE_LAT cycles letting the collider write back its tail
//   STREAM  | streaming copy, node 0..NODES-1
//   SWAP    | buffer toggled and step counted; decide next step / hold / end
//   HOLD    | parked for the host until host_hold_req_i drops
// -----------------------------------------------------------------------------
module lbm_step_sequencer #(
    parameter int NODES    = 2500,
    parameter int ADDR_W   = 12,
    parameter int PIPE_LAT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              start_i,
    input  logic [31:0]       step_target_i,
    input  logic              host_hold_req_i,
    output logic              host_hold_ack_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              stream_en_o,
    output logic [ADDR_W-1:0] stream_addr_o,
    output logic [2:0]        phase_o,
    output logic              buf_sel_o,
    output logic [31:0]       steps_done_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLIDE = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_STREAM  = 3'd3,
        ST_SWAP    = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    localparam int                DRN_W     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NODES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [DRN_W-1:0]  DRN_LOAD  = DRN_W'(PIPE_LAT - 1);
    localparam logic [DRN_W-1:0]  DRN_ONE   = DRN_W'(1);

    state_t            state_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              stream_en_q;
    logic [ADDR_W-1:0] stream_addr_q;
    logic [DRN_W-1:0]  drain_cnt_q;
    logic [31:0]       target_q;
    logic [31:0]       steps_done_q;
    logic              buf_sel_q;
    logic              busy_q;
    logic              done_q;
    logic              ack_q;

    // Write-back delay line fed from the registered read strobe/address, so
    // wr_* trail rd_* by exactly PIPE_LAT enabled cycles.
    logic              dly_en_q   [PIPE_LAT];
    logic [ADDR_W-1:0] dly_addr_q [PIPE_LAT];

    logic [31:0]       steps_done_d;

    always_comb begin
        steps_done_d = (steps_done_q == '1) ? steps_done_q : steps_done_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            stream_en_q   <= 1'b0;
            stream_addr_q <= '0;
            drain_cnt_q   <= '0;
            target_q      <= '0;
            steps_done_q  <= '0;
            buf_sel_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ack_q         <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dly_en_q[i]   <= 1'b0;
                dly_addr_q[i] <= '0;
            end
        end else if (en_i) begin
            done_q <= 1'b0;

            dly_en_q[0]   <= rd_en_q;
            dly_addr_q[0] <= rd_addr_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dly_en_q[i]   <= dly_en_q[i-1];
                dly_addr_q[i] <= dly_addr_q[i-1];
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        steps_done_q <= '0;
                        if (step_target_i == 32'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            target_q  <= step_target_i;
                            state_q   <= ST_COLLIDE;
                            busy_q    <= 1'b1;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= '0;
                        end
                    end
                end
                ST_COLLIDE: begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_q     <= ST_DRAIN;
                        rd_en_q     <= 1'b0;
                        rd_addr_q   <= '0;
                        drain_cnt_q <= DRN_LOAD;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        state_q       <= ST_STREAM;
                        stream_en_q   <= 1'b1;
                        stream_addr_q <= '0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DRN_ONE;
                    end
                end
                ST_STREAM: begin
                    if (stream_addr_q == LAST_ADDR) begin
                        state_q       <= ST_SWAP;
                        stream_en_q   <= 1'b0;
                        stream_addr_q <= '0;
                        buf_sel_q     <= ~buf_sel_q;
                        steps_done_q  <= steps_done_d;
                    end else begin
                        stream_addr_q <= stream_addr_q + ADDR_ONE;
                    end
                end
                ST_SWAP: begin
                    // Run completion takes priority over a pending host hold.
                    if (steps_done_q == target_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (host_hold_req_i) begin
                        state_q <= ST_HOLD;
                        ack_q   <= 1'b1;
                    end else begin
                        state_q   <= ST_COLLIDE;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!host_hold_req_i) begin
                        state_q   <= ST_COLLIDE;
                        ack_q     <= 1'b0;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign host_hold_ack_o = ack_q;
    assign rd_en_o         = rd_en_q;
    assign rd_addr_o       = rd_addr_q;
    assign wr_en_o         = dly_en_q[PIPE_LAT-1];
    assign wr_addr_o       = dly_addr_q[PIPE_LAT-1];
    assign stream_en_o     = stream_en_q;
    assign stream_addr_o   = stream_addr_q;
    assign phase_o         = state_q;
    assign buf_sel_o       = buf_sel_q;
    assign steps_done_o    = steps_done_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule
